// File: rtl/gpcore_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpcore_dbg_pkg
// Description : Shared types and constants for the debug-side program loader.
//               - load_state_e : loader sequencing states
//               - c_WORD_W     : stream / imem word width
//               - c_HDR_LEN_*  : location of the length field in the header
//               - hdr_len()    : extracts the word count from a header beat
// Revision    : 1.0 - initial release
// ============================================================================
package gpcore_dbg_pkg;

    localparam int c_WORD_W      = 32;
    localparam int c_HDR_LEN_LSB = 0;
    localparam int c_HDR_LEN_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } load_state_e;

    // The header carries the instruction count; it is zero-extended to a
    // full word so it can be compared directly against 32-bit counters.
    function automatic logic [c_WORD_W-1:0] hdr_len(input logic [c_WORD_W-1:0] word);
        logic [c_WORD_W-1:0] w_len;
        w_len = '0;
        w_len[c_HDR_LEN_W-1:0] = word[c_HDR_LEN_LSB +: c_HDR_LEN_W];
        return w_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : dbg_gap_timer
// Description : Idle-gap watchdog for the loader stream. Counts enabled
//               cycles since the last clear and flags the cycle that would
//               be the TIMEOUT-th consecutive idle cycle.
// Ports       : clk     in  system clock
//               nrst    in  async active-low reset
//               clr     in  restart the count (wins over en)
//               en      in  count this cycle as idle
//               expired out this enabled cycle is the TIMEOUT-th idle one
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_gap_timer #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT - 1);

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("dbg_gap_timer: TIMEOUT must be at least 1");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_at_limit;

    // r_cnt holds the number of idle cycles already seen, so the current
    // idle cycle is number r_cnt+1; expiry fires when that reaches TIMEOUT.
    assign w_at_limit = (r_cnt == c_LIMIT);
    assign expired    = en & ~clr & w_at_limit;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !w_at_limit) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Loads a program into instruction memory from a valid/ready
//               word stream (length header followed by N instruction words),
//               waits a short flush delay, then releases the core via START.
// Ports       : clk          in   system clock
//               nrst         in   async active-low reset
//               load_req     in   pulse: start (or restart) a load session
//               in_valid     in   stream word valid
//               in_data      in   stream word (header, then instructions)
//               in_ready     out  controller accepts in_data this cycle
//               DEBUG_SIG    out  imem write enable (one cycle per word)
//               DEBUG_addr   out  imem word address
//               DEBUG_instr  out  imem write data
//               START        out  core run enable
//               busy         out  session in progress (HDR/LOAD/FLUSH)
//               err          out  sticky error (bad length or stream timeout)
//               words_loaded out  words written in the current/last session
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
    import gpcore_dbg_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'd0,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          TIMEOUT      = 65535
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                load_req,
    input  logic                in_valid,
    input  logic [c_WORD_W-1:0] in_data,
    output logic                in_ready,
    output logic                DEBUG_SIG,
    output logic [31:0]         DEBUG_addr,
    output logic [c_WORD_W-1:0] DEBUG_instr,
    output logic                START,
    output logic                busy,
    output logic                err,
    output logic [31:0]         words_loaded
);

    localparam int                   c_FLUSH_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [31:0]          c_DEPTH      = 32'(DEPTH);

    generate
        if (FLUSH_CYCLES < 1) begin : g_bad_flush
            $error("imem_load_ctrl: FLUSH_CYCLES must be at least 1");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("imem_load_ctrl: DEPTH must be at least 1");
        end
        if ((64'(BASE_ADDR) + 64'(DEPTH) - 64'd1) > 64'hFFFF_FFFF) begin : g_addr_wrap
            $error("imem_load_ctrl: BASE_ADDR + DEPTH - 1 wraps the 32-bit address space");
        end
    endgenerate

    load_state_e          r_state;
    load_state_e          w_state_nxt;
    logic [31:0]          r_len;
    logic [c_FLUSH_W-1:0] r_flush_cnt;

    logic                 w_accept;
    logic                 w_streaming;
    logic                 w_last_word;
    logic [31:0]          w_hdr_len;
    logic                 w_gap_clr;
    logic                 w_gap_en;
    logic                 w_gap_expired;

    // in_ready is registered and equals "state is HDR or LOAD", so a
    // handshake never depends combinationally on in_valid.
    assign w_accept    = in_valid & in_ready;
    assign w_streaming = (r_state == ST_HDR) || (r_state == ST_LOAD);
    assign w_hdr_len   = hdr_len(in_data);
    // words_loaded doubles as the write index within the session.
    assign w_last_word = (words_loaded == (r_len - 32'd1));

    // Idle-gap watchdog: only runs in HDR/LOAD, restarted by every accepted
    // beat, by leaving those states and by a session restart.
    assign w_gap_clr = load_req | w_accept | ~w_streaming;
    assign w_gap_en  = w_streaming & ~w_accept;

    dbg_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (w_gap_clr),
        .en      (w_gap_en),
        .expired (w_gap_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load_req) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_accept) begin
                    if (w_hdr_len == 32'd0)        w_state_nxt = ST_FLUSH;
                    else if (w_hdr_len > c_DEPTH)  w_state_nxt = ST_ERR;
                    else                           w_state_nxt = ST_LOAD;
                end else if (w_gap_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_last_word) w_state_nxt = ST_FLUSH;
                end else if (w_gap_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == c_FLUSH_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
        // A load request restarts the session from any state.
        if (load_req) w_state_nxt = ST_HDR;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_len        <= 32'd0;
            r_flush_cnt  <= '0;
            in_ready     <= 1'b0;
            DEBUG_SIG    <= 1'b0;
            DEBUG_addr   <= BASE_ADDR - 32'd1;
            DEBUG_instr  <= '0;
            START        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            // Status outputs are decoded from the next state so they line
            // up with the state register rather than lagging it.
            in_ready <= (w_state_nxt == ST_HDR) || (w_state_nxt == ST_LOAD);
            busy     <= (w_state_nxt == ST_HDR) || (w_state_nxt == ST_LOAD) ||
                        (w_state_nxt == ST_FLUSH);
            START    <= (w_state_nxt == ST_RUN);
            err      <= (w_state_nxt == ST_ERR);

            // The flush counter runs only while FLUSH persists, so it is
            // zero on every entry into FLUSH.
            if ((r_state == ST_FLUSH) && (w_state_nxt == ST_FLUSH)) begin
                r_flush_cnt <= r_flush_cnt + c_FLUSH_W'(1);
            end else begin
                r_flush_cnt <= '0;
            end

            DEBUG_SIG <= 1'b0;
            if (load_req) begin
                // Restart: any beat handshaked this cycle is dropped.
                words_loaded <= 32'd0;
            end else if (w_accept && (r_state == ST_HDR)) begin
                r_len <= w_hdr_len;
            end else if (w_accept && (r_state == ST_LOAD)) begin
                DEBUG_SIG    <= 1'b1;
                DEBUG_addr   <= BASE_ADDR + words_loaded;
                DEBUG_instr  <= in_data;
                words_loaded <= words_loaded + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_ctrl
// Description : Self-checking bench for imem_load_ctrl. Stream sessions are
//               driven with random words and random idle gaps; expected imem
//               writes, START timing and status values come from the session
//               description (word list, accept cycles, flush delay).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0040;
    localparam int          FLUSH = 2;
    localparam int          TMO   = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        load_req;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        DEBUG_SIG;
    logic [31:0] DEBUG_addr;
    logic [31:0] DEBUG_instr;
    logic        START;
    logic        busy;
    logic        err;
    logic [31:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    imem_load_ctrl #(
        .DEPTH        (DEPTH),
        .BASE_ADDR    (BASE),
        .FLUSH_CYCLES (FLUSH),
        .TIMEOUT      (TMO)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .load_req     (load_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .DEBUG_SIG    (DEBUG_SIG),
        .DEBUG_addr   (DEBUG_addr),
        .DEBUG_instr  (DEBUG_instr),
        .START        (START),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed imem writes and START rising cycles.
    int unsigned wq_cyc[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int unsigned start_q[$];
    logic        prev_start = 1'b0;

    always @(negedge clk) begin
        if (DEBUG_SIG === 1'b1) begin
            wq_cyc.push_back(cyc);
            wq_addr.push_back(DEBUG_addr);
            wq_data.push_back(DEBUG_instr);
        end
        if (START === 1'b1 && prev_start !== 1'b1) start_q.push_back(cyc);
        prev_start <= START;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_debug_sig", {31'b0, DEBUG_SIG}, 32'd0);
        check("rst_debug_addr", DEBUG_addr, BASE - 32'd1);
        check("rst_debug_instr", DEBUG_instr, 32'd0);
        check("rst_start", {31'b0, START}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_words_loaded", words_loaded, 32'd0);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        sync();
        load_req = 1'b0;
    endtask

    task automatic idle(input int g);
        in_valid = 1'b0;
        repeat (g) sync();
    endtask

    // Presents one beat and holds it until the handshake edge.
    task automatic send_beat(input logic [31:0] d, output bit ok, output int unsigned acc);
        in_valid = 1'b1;
        in_data  = d;
        ok  = 1'b0;
        acc = 0;
        for (int n = 0; n < 4 * TMO && !ok; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sync();
                ok  = 1'b1;
                acc = cyc;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        if (!ok) begin
            check("beat_accepted", {31'b0, ok}, 32'd1);
            sync();
        end
    endtask

    task automatic wait_start(input int sbase);
        for (int i = 0; i < FLUSH + 12 && start_q.size() == sbase; i++) @(negedge clk);
        check("start_seen", {31'b0, start_q.size() > sbase}, 32'd1);
    endtask

    // One complete session: optional load_req, header, len words, then
    // the write list, write timing and START timing are checked.
    task automatic do_session(input bit with_req, input int len, input int maxgap);
        logic [31:0] words[$];
        int unsigned acc_q[$];
        int unsigned acc, last;
        bit          ok;
        int          wbase, sbase, nw;
        wbase = wq_addr.size();
        sbase = start_q.size();
        if (with_req) pulse_load_req();
        idle(int'($urandom_range(maxgap, 0)));
        send_beat(32'(len), ok, last);
        for (int i = 0; i < len; i++) begin
            words.push_back($urandom);
            idle(int'($urandom_range(maxgap, 0)));
            send_beat(words[i], ok, acc);
            acc_q.push_back(acc);
            last = acc;
        end
        wait_start(sbase);
        nw = wq_addr.size() - wbase;
        check("n_writes", 32'(nw), 32'(len));
        for (int i = 0; i < len && i < nw; i++) begin
            check("wr_addr", wq_addr[wbase + i], BASE + 32'(i));
            check("wr_data", wq_data[wbase + i], words[i]);
            check("wr_cycle", wq_cyc[wbase + i], acc_q[i]);
        end
        check("start_cycle", (start_q.size() > sbase) ? start_q[start_q.size() - 1] : 32'd0,
              last + FLUSH);
        check("run_start", {31'b0, START}, 32'd1);
        check("run_busy", {31'b0, busy}, 32'd0);
        check("run_in_ready", {31'b0, in_ready}, 32'd0);
        check("run_err", {31'b0, err}, 32'd0);
        check("run_words_loaded", words_loaded, 32'(len));
        sync();
    endtask

    initial begin
        int          wbase, sbase;
        bit          ok;
        int unsigned acc;

        nrst     = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        nrst = 1'b1;
        sync();
        check_reset_outputs();

        // Three back-to-back words: consecutive write cycles.
        wbase = wq_addr.size();
        do_session(1'b1, 3, 0);
        if (wq_cyc.size() >= wbase + 3)
            check("consecutive_writes", wq_cyc[wbase + 2] - wq_cyc[wbase], 32'd2);
        else
            check("consecutive_writes_count", 32'(wq_cyc.size() - wbase), 32'd3);

        // Beats offered in RUN are not taken.
        wbase = wq_addr.size();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) sync();
        in_valid = 1'b0;
        check("run_ignores_beats", 32'(wq_addr.size() - wbase), 32'd0);
        check("run_words_hold", words_loaded, 32'd3);

        // Reload from RUN: START drops next cycle, restart at BASE.
        pulse_load_req();
        check("reload_start_low", {31'b0, START}, 32'd0);
        check("reload_busy", {31'b0, busy}, 32'd1);
        check("reload_in_ready", {31'b0, in_ready}, 32'd1);
        check("reload_words_clr", words_loaded, 32'd0);
        do_session(1'b0, 2, 3);

        // Empty program.
        do_session(1'b1, 0, 2);

        // Oversized header, then recovery with a one-word program.
        wbase = wq_addr.size();
        pulse_load_req();
        send_beat(32'(DEPTH + 1), ok, acc);
        check("big_hdr_err", {31'b0, err}, 32'd1);
        check("big_hdr_busy", {31'b0, busy}, 32'd0);
        check("big_hdr_in_ready", {31'b0, in_ready}, 32'd0);
        check("big_hdr_start", {31'b0, START}, 32'd0);
        repeat (3) sync();
        check("big_hdr_no_writes", 32'(wq_addr.size() - wbase), 32'd0);
        check("err_sticky", {31'b0, err}, 32'd1);
        pulse_load_req();
        check("err_cleared", {31'b0, err}, 32'd0);
        check("err_reload_ready", {31'b0, in_ready}, 32'd1);
        do_session(1'b0, 1, 2);

        // Largest legal program.
        do_session(1'b1, DEPTH, 1);

        // Stream stall mid-LOAD: error exactly on the TMO-th idle cycle.
        wbase = wq_addr.size();
        sbase = start_q.size();
        pulse_load_req();
        send_beat(32'd4, ok, acc);
        send_beat($urandom, ok, acc);
        send_beat($urandom, ok, acc);
        repeat (TMO - 1) sync();
        check("stall_no_err_yet", {31'b0, err}, 32'd0);
        sync();
        check("stall_err", {31'b0, err}, 32'd1);
        check("stall_start", {31'b0, START}, 32'd0);
        check("stall_busy", {31'b0, busy}, 32'd0);
        check("stall_writes", 32'(wq_addr.size() - wbase), 32'd2);
        repeat (4) sync();
        check("stall_no_start", 32'(start_q.size() - sbase), 32'd0);

        // Restart mid-LOAD with a beat in flight: that beat is dropped.
        wbase = wq_addr.size();
        pulse_load_req();
        send_beat(32'd5, ok, acc);
        send_beat($urandom, ok, acc);
        send_beat($urandom, ok, acc);
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        load_req = 1'b1;
        sync();
        load_req = 1'b0;
        in_valid = 1'b0;
        check("restart_drop_sig", {31'b0, DEBUG_SIG}, 32'd0);
        check("restart_writes", 32'(wq_addr.size() - wbase), 32'd2);
        check("restart_words_clr", words_loaded, 32'd0);
        check("restart_in_ready", {31'b0, in_ready}, 32'd1);
        check("restart_busy", {31'b0, busy}, 32'd1);
        do_session(1'b0, 3, 2);

        // Asynchronous reset mid-LOAD.
        pulse_load_req();
        send_beat(32'd6, ok, acc);
        for (int i = 0; i < 3; i++) send_beat($urandom, ok, acc);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs();
        wbase = wq_addr.size();
        repeat (3) sync();
        check("rst_no_writes", 32'(wq_addr.size() - wbase), 32'd0);
        in_valid = 1'b0;
        nrst = 1'b1;
        sync();
        check("rst_idle_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_idle_busy", {31'b0, busy}, 32'd0);

        // Random programs with random gaps up to the timeout boundary.
        for (int s = 0; s < 5; s++) begin
            do_session(1'b1, int'($urandom_range(DEPTH, 1)), TMO - 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
